// File: rtl/fft_pkg.sv
// Shared widths and fixed-point helpers for the FFT butterfly datapath.
// Every derived width is computed from the DATA_W / TW_W actually in use.
package fft_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int TW_W_DEF   = 16;

    // Per-sample controls that travel alongside the data.
    typedef struct packed {
        logic inverse;
        logic scale;
    } ctrl_t;

    function automatic int prod_w(input int dw, input int tw);
        return dw + tw;
    endfunction

    function automatic int sum_w(input int dw, input int tw);
        return dw + tw + 1;
    endfunction

    function automatic int p_w(input int dw);
        return dw + 2;
    endfunction

    // Half an LSB of the result after the Q1.(tw-1) rescale.
    function automatic longint rnd_const(input int tw);
        return longint'(1) << (tw - 2);
    endfunction

    function automatic longint sat_max(input int dw);
        return (longint'(1) << (dw - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int dw);
        return -(longint'(1) << (dw - 1));
    endfunction

endpackage

// File: rtl/cmplx_mult_q.sv
// Pipelined complex multiply B*W (or B*conj(W)): four products, then add/sub and
// round-half-up back to data scale. Two register stages, both held when en=0.
module cmplx_mult_q
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   i_b_r,
    input  logic signed [DATA_W-1:0]   i_b_i,
    input  logic signed [TW_W-1:0]     i_w_r,
    input  logic signed [TW_W-1:0]     i_w_i,
    input  logic                       i_inverse,
    output logic signed [DATA_W+1:0]   o_p_r,
    output logic signed [DATA_W+1:0]   o_p_i
);

    localparam int PROD_W = prod_w(DATA_W, TW_W);
    localparam int SUM_W  = sum_w(DATA_W, TW_W);
    localparam int P_W    = p_w(DATA_W);
    localparam logic signed [SUM_W-1:0] RND = SUM_W'(rnd_const(TW_W));

    logic signed [PROD_W-1:0] rr_q, ii_q, ir_q, ri_q;
    logic signed [PROD_W-1:0] rr_d, ii_d, ir_d, ri_d;
    logic                     inv_q, inv_d;
    logic signed [SUM_W-1:0]  sum_r, sum_i, rnd_r, rnd_i;
    logic signed [P_W-1:0]    p_r_q, p_i_q, p_r_d, p_i_d;

    always_comb begin
        rr_d  = rr_q;
        ii_d  = ii_q;
        ir_d  = ir_q;
        ri_d  = ri_q;
        inv_d = inv_q;
        p_r_d = p_r_q;
        p_i_d = p_i_q;
        // Conjugation flips the add/sub rather than negating W, so W_i = -1.0 stays exact.
        sum_r = inv_q ? SUM_W'(rr_q) + SUM_W'(ii_q) : SUM_W'(rr_q) - SUM_W'(ii_q);
        sum_i = inv_q ? SUM_W'(ir_q) - SUM_W'(ri_q) : SUM_W'(ir_q) + SUM_W'(ri_q);
        rnd_r = (sum_r + RND) >>> (TW_W - 1);
        rnd_i = (sum_i + RND) >>> (TW_W - 1);
        if (en) begin
            rr_d  = PROD_W'(i_b_r) * PROD_W'(i_w_r);
            ii_d  = PROD_W'(i_b_i) * PROD_W'(i_w_i);
            ir_d  = PROD_W'(i_b_i) * PROD_W'(i_w_r);
            ri_d  = PROD_W'(i_b_r) * PROD_W'(i_w_i);
            inv_d = i_inverse;
            p_r_d = P_W'(rnd_r);
            p_i_d = P_W'(rnd_i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q  <= '0;
            ii_q  <= '0;
            ir_q  <= '0;
            ri_q  <= '0;
            inv_q <= 1'b0;
            p_r_q <= '0;
            p_i_q <= '0;
        end else begin
            rr_q  <= rr_d;
            ii_q  <= ii_d;
            ir_q  <= ir_d;
            ri_q  <= ri_d;
            inv_q <= inv_d;
            p_r_q <= p_r_d;
            p_i_q <= p_i_d;
        end
    end

    assign o_p_r = p_r_q;
    assign o_p_i = p_i_q;

endmodule

// File: rtl/radix2_butterfly_pipe.sv
// Four-stage radix-2 DIT butterfly A' = A + W*B, B' = A - W*B with optional /2,
// saturation and a sticky overflow flag. One global stall enable holds every stage.
module radix2_butterfly_pipe
    import fft_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int TW_W   = TW_W_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] i_data_ra,
    input  logic signed [DATA_W-1:0] i_data_ca,
    input  logic signed [DATA_W-1:0] i_data_rb,
    input  logic signed [DATA_W-1:0] i_data_cb,
    input  logic signed [TW_W-1:0]   i_twiddle_r,
    input  logic signed [TW_W-1:0]   i_twiddle_c,
    input  logic                     i_inverse,
    input  logic                     i_scale,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DATA_W-1:0] o_data_ra,
    output logic signed [DATA_W-1:0] o_data_ca,
    output logic signed [DATA_W-1:0] o_data_rb,
    output logic signed [DATA_W-1:0] o_data_cb,
    output logic                     o_ovf,
    input  logic                     i_ovf_clr
);

    localparam int P_W = p_w(DATA_W);
    localparam logic signed [P_W-1:0] SAT_MAX = P_W'(sat_max(DATA_W));
    localparam logic signed [P_W-1:0] SAT_MIN = P_W'(sat_min(DATA_W));

    // Returns {saturated, clamped value}.
    function automatic logic [DATA_W:0] sat_fn(input logic signed [P_W-1:0] x);
        if (x > SAT_MAX)      return {1'b1, SAT_MAX[DATA_W-1:0]};
        else if (x < SAT_MIN) return {1'b1, SAT_MIN[DATA_W-1:0]};
        else                  return {1'b0, DATA_W'(x)};
    endfunction

    function automatic logic signed [P_W-1:0] scale_fn(input logic signed [P_W-1:0] x,
                                                       input logic s);
        return s ? (x + P_W'(1)) >>> 1 : x;
    endfunction

    logic en;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_a_r_q, s1_a_i_q, s1_b_r_q, s1_b_i_q;
    logic signed [DATA_W-1:0] s1_a_r_d, s1_a_i_d, s1_b_r_d, s1_b_i_d;
    logic signed [TW_W-1:0]   s1_w_r_q, s1_w_i_q, s1_w_r_d, s1_w_i_d;
    ctrl_t                    s1_ctrl_q, s1_ctrl_d;

    logic                     s2_valid_q, s2_valid_d, s2_scale_q, s2_scale_d;
    logic signed [DATA_W-1:0] s2_a_r_q, s2_a_i_q, s2_a_r_d, s2_a_i_d;
    logic                     s3_valid_q, s3_valid_d, s3_scale_q, s3_scale_d;
    logic signed [DATA_W-1:0] s3_a_r_q, s3_a_i_q, s3_a_r_d, s3_a_i_d;
    logic signed [P_W-1:0]    p_r, p_i;

    logic signed [P_W-1:0]    sum_ar, sum_ai, sum_br, sum_bi;
    logic [DATA_W:0]          sat_ar, sat_ai, sat_br, sat_bi;
    logic                     sat_any;

    logic                     out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic signed [DATA_W-1:0] o_ra_q, o_ca_q, o_rb_q, o_cb_q;
    logic signed [DATA_W-1:0] o_ra_d, o_ca_d, o_rb_d, o_cb_d;

    assign en       = out_ready | ~out_valid_q;
    assign in_ready = en;

    cmplx_mult_q #(.DATA_W(DATA_W), .TW_W(TW_W)) u_mult (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .i_b_r     (s1_b_r_q),
        .i_b_i     (s1_b_i_q),
        .i_w_r     (s1_w_r_q),
        .i_w_i     (s1_w_i_q),
        .i_inverse (s1_ctrl_q.inverse),
        .o_p_r     (p_r),
        .o_p_i     (p_i)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_r_d   = s1_a_r_q;
        s1_a_i_d   = s1_a_i_q;
        s1_b_r_d   = s1_b_r_q;
        s1_b_i_d   = s1_b_i_q;
        s1_w_r_d   = s1_w_r_q;
        s1_w_i_d   = s1_w_i_q;
        s1_ctrl_d  = s1_ctrl_q;
        s2_valid_d = s2_valid_q;
        s2_scale_d = s2_scale_q;
        s2_a_r_d   = s2_a_r_q;
        s2_a_i_d   = s2_a_i_q;
        s3_valid_d = s3_valid_q;
        s3_scale_d = s3_scale_q;
        s3_a_r_d   = s3_a_r_q;
        s3_a_i_d   = s3_a_i_q;
        out_valid_d = out_valid_q;
        o_ra_d = o_ra_q;
        o_ca_d = o_ca_q;
        o_rb_d = o_rb_q;
        o_cb_d = o_cb_q;

        sum_ar  = scale_fn(P_W'(s3_a_r_q) + p_r, s3_scale_q);
        sum_ai  = scale_fn(P_W'(s3_a_i_q) + p_i, s3_scale_q);
        sum_br  = scale_fn(P_W'(s3_a_r_q) - p_r, s3_scale_q);
        sum_bi  = scale_fn(P_W'(s3_a_i_q) - p_i, s3_scale_q);
        sat_ar  = sat_fn(sum_ar);
        sat_ai  = sat_fn(sum_ai);
        sat_br  = sat_fn(sum_br);
        sat_bi  = sat_fn(sum_bi);
        sat_any = s3_valid_q & (sat_ar[DATA_W] | sat_ai[DATA_W] |
                                sat_br[DATA_W] | sat_bi[DATA_W]);
        // A saturating result landing in the output register beats a same-cycle clear.
        ovf_d   = (ovf_q & ~i_ovf_clr) | (en & sat_any);

        if (en) begin
            s1_valid_d        = in_valid;
            s1_a_r_d          = i_data_ra;
            s1_a_i_d          = i_data_ca;
            s1_b_r_d          = i_data_rb;
            s1_b_i_d          = i_data_cb;
            s1_w_r_d          = i_twiddle_r;
            s1_w_i_d          = i_twiddle_c;
            s1_ctrl_d.inverse = i_inverse;
            s1_ctrl_d.scale   = i_scale;
            s2_valid_d        = s1_valid_q;
            s2_scale_d        = s1_ctrl_q.scale;
            s2_a_r_d          = s1_a_r_q;
            s2_a_i_d          = s1_a_i_q;
            s3_valid_d        = s2_valid_q;
            s3_scale_d        = s2_scale_q;
            s3_a_r_d          = s2_a_r_q;
            s3_a_i_d          = s2_a_i_q;
            out_valid_d       = s3_valid_q;
            o_ra_d            = sat_ar[DATA_W-1:0];
            o_ca_d            = sat_ai[DATA_W-1:0];
            o_rb_d            = sat_br[DATA_W-1:0];
            o_cb_d            = sat_bi[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_r_q    <= '0;
            s1_a_i_q    <= '0;
            s1_b_r_q    <= '0;
            s1_b_i_q    <= '0;
            s1_w_r_q    <= '0;
            s1_w_i_q    <= '0;
            s1_ctrl_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_scale_q  <= 1'b0;
            s2_a_r_q    <= '0;
            s2_a_i_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_scale_q  <= 1'b0;
            s3_a_r_q    <= '0;
            s3_a_i_q    <= '0;
            out_valid_q <= 1'b0;
            o_ra_q      <= '0;
            o_ca_q      <= '0;
            o_rb_q      <= '0;
            o_cb_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_r_q    <= s1_a_r_d;
            s1_a_i_q    <= s1_a_i_d;
            s1_b_r_q    <= s1_b_r_d;
            s1_b_i_q    <= s1_b_i_d;
            s1_w_r_q    <= s1_w_r_d;
            s1_w_i_q    <= s1_w_i_d;
            s1_ctrl_q   <= s1_ctrl_d;
            s2_valid_q  <= s2_valid_d;
            s2_scale_q  <= s2_scale_d;
            s2_a_r_q    <= s2_a_r_d;
            s2_a_i_q    <= s2_a_i_d;
            s3_valid_q  <= s3_valid_d;
            s3_scale_q  <= s3_scale_d;
            s3_a_r_q    <= s3_a_r_d;
            s3_a_i_q    <= s3_a_i_d;
            out_valid_q <= out_valid_d;
            o_ra_q      <= o_ra_d;
            o_ca_q      <= o_ca_d;
            o_rb_q      <= o_rb_d;
            o_cb_q      <= o_cb_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign o_data_ra = o_ra_q;
    assign o_data_ca = o_ca_q;
    assign o_data_rb = o_rb_q;
    assign o_data_cb = o_cb_q;
    assign o_ovf     = ovf_q;

endmodule

// File: tb/tb_radix2_butterfly_pipe.sv
// Bench for radix2_butterfly_pipe: directed vectors with hand-computed results plus
// a scoreboard fed by an independent arithmetic model of the butterfly.
module tb_radix2_butterfly_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] i_data_ra = '0, i_data_ca = '0, i_data_rb = '0, i_data_cb = '0;
    logic [15:0] i_twiddle_r = '0, i_twiddle_c = '0;
    logic        i_inverse = 1'b0, i_scale = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] o_data_ra, o_data_ca, o_data_rb, o_data_cb;
    logic        o_ovf;
    logic        i_ovf_clr = 1'b0;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          n_out = 0;
    logic [63:0] exp_q[$];

    // clock / reset
    always #5 clk = ~clk;

    radix2_butterfly_pipe #(.DATA_W(16), .TW_W(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .i_data_ra(i_data_ra), .i_data_ca(i_data_ca),
        .i_data_rb(i_data_rb), .i_data_cb(i_data_cb),
        .i_twiddle_r(i_twiddle_r), .i_twiddle_c(i_twiddle_c),
        .i_inverse(i_inverse), .i_scale(i_scale),
        .out_valid(out_valid), .out_ready(out_ready),
        .o_data_ra(o_data_ra), .o_data_ca(o_data_ca),
        .o_data_rb(o_data_rb), .o_data_cb(o_data_cb),
        .o_ovf(o_ovf), .i_ovf_clr(i_ovf_clr)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [15:0] ra, ca, rb, cb, wr, wi,
                                          input logic inv, sc);
        longint ar  = longint'($signed(ra));
        longint ai  = longint'($signed(ca));
        longint br  = longint'($signed(rb));
        longint bi  = longint'($signed(cb));
        longint wrs = longint'($signed(wr));
        longint wis = longint'($signed(wi));
        longint pr, pi;
        longint o[4];
        pr = inv ? br * wrs + bi * wis : br * wrs - bi * wis;
        pi = inv ? bi * wrs - br * wis : bi * wrs + br * wis;
        pr = (pr + 16384) >>> 15;
        pi = (pi + 16384) >>> 15;
        o[0] = ar + pr;
        o[1] = ai + pi;
        o[2] = ar - pr;
        o[3] = ai - pi;
        for (int k = 0; k < 4; k++) begin
            if (sc) o[k] = (o[k] + 1) >>> 1;
            if (o[k] > 32767)  o[k] = 32767;
            if (o[k] < -32768) o[k] = -32768;
        end
        return {16'(o[0]), 16'(o[1]), 16'(o[2]), 16'(o[3])};
    endfunction

    // scoreboard: push on accept, pop on output transfer
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                n_out++;
                if (exp_q.size() == 0) check_val("sb_extra_out", 64'd1, 64'd0);
                else check_val("sb_out", {o_data_ra, o_data_ca, o_data_rb, o_data_cb},
                               exp_q.pop_front());
            end
            if (in_valid && in_ready)
                exp_q.push_back(model(i_data_ra, i_data_ca, i_data_rb, i_data_cb,
                                      i_twiddle_r, i_twiddle_c, i_inverse, i_scale));
        end
    end

    task automatic set_inputs(input logic [15:0] ra, ca, rb, cb, wr, wi, input logic inv, sc);
        i_data_ra = ra; i_data_ca = ca; i_data_rb = rb; i_data_cb = cb;
        i_twiddle_r = wr; i_twiddle_c = wi; i_inverse = inv; i_scale = sc;
    endtask

    // Drive one butterfly into an idle pipe and wait for its result; lat counts
    // clock edges from the accepting edge up to the one raising out_valid.
    task automatic run_one(input logic [15:0] ra, ca, rb, cb, wr, wi,
                           input logic inv, sc, output int lat);
        set_inputs(ra, ca, rb, cb, wr, wi, inv, sc);
        in_valid = 1'b1;
        lat = 0;
        while (lat < 12) begin
            @(posedge clk);
            #1;
            if (lat == 0) in_valid = 1'b0;
            lat++;
            if (out_valid) break;
        end
    endtask

    task automatic check_out(input string tag, input logic [15:0] ra, ca, rb, cb);
        check_val({tag, "_valid"}, out_valid, 1'b1);
        check_val({tag, "_data"}, {o_data_ra, o_data_ca, o_data_rb, o_data_cb},
                  {ra, ca, rb, cb});
    endtask

    initial begin
        int lat;
        int g;
        int seen;

        // reset
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 1'b0);
        check_val("rst_data", {o_data_ra, o_data_ca, o_data_rb, o_data_cb}, 64'd0);
        check_val("rst_ovf", o_ovf, 1'b0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_val("rst_in_ready", in_ready, 1'b1);

        // legacy vector
        run_one(16'd1, 16'd2, 16'd3, 16'd4, 16'h7FFF, 16'h0000, 1'b0, 1'b0, lat);
        check_val("legacy_lat", lat, 4);
        check_out("legacy", 16'd4, 16'd6, 16'hFFFE, 16'hFFFE);
        check_val("legacy_ovf", o_ovf, 1'b0);

        // W = -j, forward and inverse
        run_one(16'd1, 16'd2, 16'd3, 16'd4, 16'h0000, 16'h8000, 1'b0, 1'b0, lat);
        check_out("mj_fwd", 16'd5, 16'hFFFF, 16'hFFFD, 16'd5);
        run_one(16'd1, 16'd2, 16'd3, 16'd4, 16'h0000, 16'h8000, 1'b1, 1'b0, lat);
        check_out("mj_inv", 16'hFFFD, 16'd5, 16'd5, 16'hFFFF);

        // saturation without scaling
        run_one(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0, 1'b0, lat);
        check_out("sat_noscale", 16'h7FFF, 16'd0, 16'd1, 16'd0);
        check_val("sat_noscale_ovf", o_ovf, 1'b1);

        i_ovf_clr = 1'b1;
        @(posedge clk);
        #1;
        i_ovf_clr = 1'b0;
        check_val("ovf_cleared", o_ovf, 1'b0);

        // same with scaling: fits, so no overflow
        run_one(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0, 1'b1, lat);
        check_out("sat_scale", 16'h7FFF, 16'd0, 16'd1, 16'd0);
        check_val("sat_scale_ovf", o_ovf, 1'b0);

        // set and clear in the same cycle
        i_ovf_clr = 1'b1;
        run_one(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0, 1'b0, lat);
        check_val("collide_ovf", o_ovf, 1'b1);
        @(posedge clk);
        #1;
        check_val("collide_ovf_after", o_ovf, 1'b0);
        i_ovf_clr = 1'b0;

        // backpressure: 8 back-to-back, 3-cycle stall after the 2nd output
        n_out = 0;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    logic acc;
                    int   guard;
                    set_inputs(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                               16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    in_valid = 1'b1;
                    guard = 0;
                    acc = 1'b0;
                    while (!acc && guard < 30) begin
                        @(negedge clk);
                        acc = in_ready;
                        @(posedge clk);
                        #1;
                        guard++;
                    end
                    if (!acc) check_val("bp_accept_timeout", 64'd1, 64'd0);
                end
                in_valid = 1'b0;
            end
            begin
                int gg = 0;
                while (n_out < 2 && gg < 100) begin
                    @(posedge clk);
                    #1;
                    gg++;
                end
                check_val("bp_reach2", 64'(n_out >= 2), 64'd1);
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check_val("bp_in_ready_low", in_ready, 1'b0);
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        g = 0;
        while (exp_q.size() != 0 && g < 50) begin
            @(posedge clk);
            #1;
            g++;
        end
        check_val("bp_drain", exp_q.size(), 0);
        check_val("bp_count", n_out, 8);

        // reset with 3 samples in flight and o_ovf set
        run_one(16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 16'h7FFF, 16'd0, 1'b0, 1'b0, lat);
        check_val("rs_ovf_pre", o_ovf, 1'b1);
        for (int i = 0; i < 3; i++) begin
            set_inputs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'(16'h7FF0 + i), 16'h7FFF, 16'd0,
                       1'b0, 1'b0);
            in_valid = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk);
        #1;
        check_val("rs_out_valid", out_valid, 1'b0);
        check_val("rs_data", {o_data_ra, o_data_ca, o_data_rb, o_data_cb}, 64'd0);
        check_val("rs_ovf", o_ovf, 1'b0);
        rst = 1'b0;
        check_val("rs_in_ready", in_ready, 1'b1);
        seen = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        check_val("rs_no_leak", seen, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/radix2_butterfly_pipe.md
# radix2_butterfly_pipe

Parametrised, fully pipelined radix-2 decimation-in-time butterfly: A' = A + W·B, B' = A − W·B on signed fixed-point complex samples with a Q1.(TW_W−1) twiddle. Adds valid/ready flow control, per-sample forward/inverse selection (conjugate twiddle), optional ÷2 stage scaling, rounding, output saturation and a sticky overflow flag. It sits between the stage memory/address generator and the twiddle ROM in each FFT stage and accepts one butterfly per clock.

## Interface
- DATA_W, 16: signed width of each real/imag data component
- TW_W, 16: signed width of each twiddle component, format Q1.(TW_W−1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  input butterfly present
- in_ready  out  1  block can accept input this cycle
- i_data_ra, i_data_ca, i_data_rb, i_data_cb  in  DATA_W each  A and B, real/imag
- i_twiddle_r, i_twiddle_c  in  TW_W each  twiddle W
- i_inverse  in  1  use conj(W)
- i_scale  in  1  divide both outputs by 2
- out_valid  out  1  output butterfly present
- out_ready  in  1  downstream accepts output
- o_data_ra, o_data_ca, o_data_rb, o_data_cb  out  DATA_W each  A', B'
- o_ovf  out  1  sticky: some output saturated since reset/clear
- i_ovf_clr  in  1  clears o_ovf

## Operation
- Control bits (i_inverse, i_scale) travel with each sample down the pipeline.
- S1: register A, B, W, controls, valid.
- S2: four signed products Br·Wr, Bi·Wi, Bi·Wr, Br·Wi, each DATA_W+TW_W bits, registered.
- S3: forward: Pr = Br·Wr − Bi·Wi, Pi = Bi·Wr + Br·Wi; inverse: Pr = Br·Wr + Bi·Wi, Pi = Bi·Wr − Br·Wi. Conjugation is by add/sub selection, never by negating Wc (so W = −1.0 i.e. 0x8000 works in both modes). Sums are DATA_W+TW_W+1 bits. Round half-up: add 2^(TW_W−2), arithmetic shift right TW_W−1; registered at DATA_W+2 bits.
- S4: A ± P at DATA_W+2 bits; if scale, add 1 then arithmetic shift right 1; saturate to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; register outputs.
- o_ovf sets on any component saturating in a transferred S4 result; i_ovf_clr clears it; set wins over clear in the same cycle.
- Bubbles (in_valid=0) propagate as invalid slots; data registers of invalid slots may hold stale values.

## Timing
- Latency 4 cycles from accepted input (in_valid & in_ready) to out_valid, with no stall.
- Throughput 1 butterfly/clock.
- Global stall: en = out_ready | ~out_valid; in_ready = en (combinational). When en=0 all stages hold.
- out_valid and outputs stay stable while out_valid & ~out_ready.
- rst: all valid bits 0, all o_data_* 0, o_ovf 0 on the next edge; in-flight samples are discarded; in_ready = 1 the cycle after reset.
- Reset during a stall discards the held output.
- Inputs with in_valid=1 and in_ready=0 are not taken; the source must hold them.

## Structure
- Shared package fft_pkg: DATA_W and TW_W defaults, derived product/sum widths, Q-format round-constant localparam, saturation limit constants.
- One sub-module: cmplx_mult_q (stages S2–S3: four products, inverse-selected add/sub, rounding; stall enable input). Butterfly add/sub, scaling, saturation, handshake, ovf in the top.

## Test plan
- Legacy vector: A=(1,2), B=(3,4), W=(0x7FFF,0), fwd, no scale -> after 4 cycles A'=(4,6), B'=(−2,−2), o_ovf=0.
- W=(0,0x8000) (−j), A=(1,2), B=(3,4): forward -> A'=(5,−1), B'=(−3,5); inverse -> A'=(−3,5), B'=(5,−1).
- Saturation: A=(0x7FFF,0), B=(0x7FFF,0), W=(0x7FFF,0), no scale -> A'r=0x7FFF, B'r=1, o_ovf=1; same with scale=1 -> A'r=0x7FFF, B'r=1, o_ovf unchanged after a prior i_ovf_clr (stays 0).
- Backpressure: stream 8 random butterflies back-to-back, drop out_ready for 3 cycles after the 2nd output -> in_ready low for those 3 cycles, all 8 outputs match the golden model in order, no duplicates.
- Reset mid-stream: assert rst with 3 samples in flight -> next cycle out_valid=0, outputs 0, o_ovf=0; no pre-reset sample ever appears at the output.
- Ovf clear collision: saturating result transfers in the same cycle as i_ovf_clr=1 -> o_ovf=1.
